alu_cmd_sequencer: RTL

// Upstream issue stage for the 8-bit clocked ALU. Buffers ALU commands (A, B, ALU_Sel) in a small FIFO.

---
 rtl/alu_cmd_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// Issue stage in front of the 8-bit clocked ALU: buffers commands, rejects illegal ones,
// dispatches one legal command at a time and returns the captured result over valid/ready.
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [7:0]                   cmd_a,
  input  logic [7:0]                   cmd_b,
  input  logic [3:0]                   cmd_sel,
  output logic [7:0]                   alu_a,
  output logic [7:0]                   alu_b,
  output logic [3:0]                   alu_sel,
  input  logic [7:0]                   alu_out,
  input  logic                         alu_carry,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [7:0]                   rsp_data,
  output logic                         rsp_carry,
  output logic [1:0]                   rsp_err,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int LAT_W = $clog2(ALU_LAT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ALU_LAT);
  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_OPC  = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [19:0]      fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LAT_W-1:0] cnt;
  logic             push, pop, issue, fault, capture, rsp_take;
  logic [7:0]       head_a, head_b;
  logic [3:0]       head_sel;
  logic [1:0]       head_err;

  // An unsupported opcode outranks divide-by-zero.
  function automatic logic [1:0] classify(input logic [7:0] b, input logic [3:0] sel);
    if (sel > 4'd3)
      return ERR_OPC;
    else if (sel == 4'd3 && b == 8'd0)
      return ERR_DIV0;
    else
      return ERR_OK;
  endfunction

  // ---- stage p0: FIFO head and classification ----
  assign cmd_ready = (fifo_count < FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  assign {head_a, head_b, head_sel} = fifo_mem[rd_ptr];
  assign head_err  = classify(head_b, head_sel);
  assign rsp_take  = (state == RESP) && rsp_ready;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    issue     = 1'b0;
    fault     = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: pop = (fifo_count != '0);
      EXEC: begin
        if (cnt == LAT_LAST) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          if (fifo_count != '0) pop = 1'b1;
          else                  state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (pop) begin
      if (head_err == ERR_OK) begin
        issue     = 1'b1;
        state_nxt = EXEC;
      end else begin
        fault     = 1'b1;
        state_nxt = RESP;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_a, cmd_b, cmd_sel};
  end

  // ---- stage p1: ALU issue, latency count and response capture ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_err   <= ERR_OK;
    end else begin
      if (issue) begin
        alu_a   <= head_a;
        alu_b   <= head_b;
        alu_sel <= head_sel;
        cnt     <= '0;
      end else if (state == EXEC) begin
        cnt <= cnt + LAT_W'(1);
      end

      if (capture) begin
        rsp_valid <= 1'b1;
        rsp_data  <= alu_out;
        rsp_carry <= alu_carry;
        rsp_err   <= ERR_OK;
      end else if (fault) begin
        rsp_valid <= 1'b1;
        rsp_data  <= '0;
        rsp_carry <= 1'b0;
        rsp_err   <= head_err;
      end else if (rsp_take) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
